// File: rtl/rv32_mem_arbiter.sv
// Two-master (fetch m0 / data m1) arbiter onto one shared memory slave, with an
// atomic LOCK hold for m1 and a slave wait timeout. Optional macro: ARB_ROUND_ROBIN_EN.
`ifndef RstEnable
`define RstEnable 1'b1
`endif

module rv32_mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_lock_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, LOCK} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait;
  logic        w_rst;
  logic        w_timeout;
  logic        w_pick_m0;
  logic        w_g0;
  logic        w_g1;

  assign w_rst     = (rst_i == `RstEnable);
  assign w_timeout = (r_wait == TIMEOUT) && !s_ack_i;

`ifdef ARB_ROUND_ROBIN_EN
  // 0: m1 was granted last (so m0 wins a tie); 1: m0 was granted last.
  logic r_rr_ptr;

  assign w_pick_m0 = m0_req_i && (!m1_req_i || !r_rr_ptr);

  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_next == GNT0 && r_state != GNT0) begin
      r_rr_ptr <= 1'b1;
    end else if (w_next == GNT1 && r_state != GNT1) begin
      r_rr_ptr <= 1'b0;
    end
  end
`else
  assign w_pick_m0 = m0_req_i && !m1_req_i;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_m0) begin
          w_next = GNT0;
        end else if (m1_req_i) begin
          w_next = GNT1;
        end
      end
      GNT0: begin
        if (s_ack_i || w_timeout) begin
          w_next = IDLE;
        end
      end
      GNT1: begin
        if (s_ack_i) begin
          w_next = m1_lock_i ? LOCK : IDLE;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end
      LOCK: begin
        if (m1_req_i) begin
          w_next = GNT1;
        end else if (!m1_lock_i) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Counter sits at 0 outside GNTx, so it is already clear on entry.
  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_state <= IDLE;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == GNT0 || r_state == GNT1) begin
        if (!s_ack_i) begin
          r_wait <= r_wait + 8'd1;
        end
      end else begin
        r_wait <= 8'd0;
      end
    end
  end

  // Outputs are forced low while reset is asserted, even mid-transfer.
  assign w_g0 = (r_state == GNT0) && !w_rst;
  assign w_g1 = (r_state == GNT1) && !w_rst;

  always_comb begin
    s_req_o    = w_g0 | w_g1;
    s_we_o     = 1'b0;
    s_sel_o    = 4'h0;
    s_addr_o   = 32'h0;
    s_wdata_o  = 32'h0;
    m0_rdata_o = 32'h0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_rdata_o = 32'h0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    if (w_g0) begin
      s_sel_o    = 4'hF;
      s_addr_o   = m0_addr_i;
      m0_rdata_o = s_rdata_i;
      // A master that dropped its request mid-transfer gets no completion.
      m0_ack_o   = s_ack_i && m0_req_i;
      m0_err_o   = w_timeout && m0_req_i;
    end else if (w_g1) begin
      s_we_o     = m1_we_i;
      s_sel_o    = m1_sel_i;
      s_addr_o   = m1_addr_i;
      s_wdata_o  = m1_wdata_i;
      m1_rdata_o = s_rdata_i;
      m1_ack_o   = s_ack_i && m1_req_i;
      m1_err_o   = w_timeout && m1_req_i;
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter: a transaction-level ownership model checked
// every cycle, plus literal expectations for latency, grant order, lock and timeout.
module tb_rv32_mem_arbiter;

  localparam logic [7:0] TO = 8'd4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_rdata_o;
  logic        m0_ack_o;
  logic        m0_err_o;
  logic        m1_req_i;
  logic        m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_lock_i;
  logic [31:0] m1_rdata_o;
  logic        m1_ack_o;
  logic        m1_err_o;
  logic        s_req_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [31:0] s_rdata_i;
  logic        s_ack_i;

  rv32_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_rdata_o(m0_rdata_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Ownership view: who holds the slave (-1 none), how long it has waited,
  // whether m1 holds the atomic lock, and who should win the next tie.
  int m_owner   = -1;
  int m_waited  = 0;
  bit m_held    = 1'b0;
  bit m_pref_m0 = 1'b1;
  bit m_pick_m0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_owner = -1; m_waited = 0; m_held = 1'b0; m_pref_m0 = 1'b1;
    end else if (m_owner >= 0) begin
      if (s_ack_i) begin
        m_held  = (m_owner == 1) && m1_lock_i;
        m_owner = -1;
      end else if (m_waited == int'(TO)) begin
        m_held  = 1'b0;
        m_owner = -1;
      end else begin
        m_waited++;
      end
    end else if (m_held) begin
      if (m1_req_i) begin
        m_owner = 1; m_waited = 0; m_pref_m0 = 1'b1;
      end else if (!m1_lock_i) begin
        m_held = 1'b0;
      end
    end else if (m0_req_i || m1_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      m_pick_m0 = m0_req_i && (!m1_req_i || m_pref_m0);
`else
      m_pick_m0 = m0_req_i && !m1_req_i;
`endif
      m_owner   = m_pick_m0 ? 0 : 1;
      m_waited  = 0;
      m_pref_m0 = !m_pick_m0;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit started = 1'b0;
  logic [137:0] exp_v;
  logic [137:0] act_v;
  bit g0;
  bit g1;
  bit tmo;

  always @(negedge clk_i) begin
    if (started) begin
      g0  = !rst_i && (m_owner == 0);
      g1  = !rst_i && (m_owner == 1);
      tmo = !s_ack_i && (m_waited == int'(TO));
      exp_v = {g0 | g1, g1 && m1_we_i,
               g0 ? 4'hF : (g1 ? m1_sel_i : 4'h0),
               g0 ? m0_addr_i : (g1 ? m1_addr_i : 32'h0),
               g1 ? m1_wdata_i : 32'h0,
               g0 ? s_rdata_i : 32'h0, g0 && s_ack_i && m0_req_i, g0 && tmo && m0_req_i,
               g1 ? s_rdata_i : 32'h0, g1 && s_ack_i && m1_req_i, g1 && tmo && m1_req_i};
      act_v = {s_req_o, s_we_o, s_sel_o, s_addr_o, s_wdata_o,
               m0_rdata_o, m0_ack_o, m0_err_o, m1_rdata_o, m1_ack_o, m1_err_o};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL cycle_outputs @%0t: got %h expected %h", $time, act_v, exp_v);
      end
    end
  end

  // Grant order as seen on the slave port (1 = m1 address 0x100).
  bit          log_en = 1'b0;
  bit          prev_req = 1'b0;
  logic [0:0]  got_q[$];
  logic [0:0]  exp_q[$];

  always @(negedge clk_i) begin
    if (log_en && s_req_o && !prev_req) begin
      got_q.push_back(s_addr_o == 32'h100);
    end
    prev_req = s_req_o;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_i = 1'b0; m0_addr_i = 32'h0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 4'h0; m1_addr_i = 32'h0;
    m1_wdata_i = 32'h0; m1_lock_i = 1'b0; s_rdata_i = 32'h0; s_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wait_sreq(input string name);
    int n = 0;
    while (!s_req_o && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (!s_req_o) begin
      bad++;
      $display("FAIL %s: s_req_o got 0 expected 1 within 20 cycles", name);
    end
  endtask

  // Slave answers after `waits` further cycles with a one-cycle ack pulse.
  task automatic serve(input int waits, input logic [31:0] rdata);
    repeat (waits) tick();
    s_ack_i = 1'b1; s_rdata_i = rdata;
    tick();
    s_ack_i = 1'b0; s_rdata_i = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    started = 1'b1;
    check("reset_sreq", 32'(s_req_o), 32'd0);
    check("reset_acks", {28'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    check("post_reset_addr", s_addr_o, 32'h0);

    // Single fetch
    m0_req_i = 1'b1; m0_addr_i = 32'h0000_0010;
    #1 check("fetch_lat0", 32'(s_req_o), 32'd0);
    tick();
    check("fetch_sreq", 32'(s_req_o), 32'd1);
    check("fetch_addr", s_addr_o, 32'h0000_0010);
    check("fetch_sel", 32'(s_sel_o), 32'hF);
    tick();
    tick();
    s_ack_i = 1'b1; s_rdata_i = 32'h0000_0013;
    #1 check("fetch_ack", 32'(m0_ack_o), 32'd1);
    check("fetch_rdata", m0_rdata_o, 32'h0000_0013);
    tick();
    s_ack_i = 1'b0; s_rdata_i = 32'h0; m0_req_i = 1'b0;
    check("fetch_turnaround", 32'(s_req_o), 32'd0);
    tick();
    check("fetch_idle", 32'(s_req_o), 32'd0);

    // Three back-to-back simultaneous pairs
    do_reset();
    m0_addr_i = 32'h200;
    m1_addr_i = 32'h100; m1_we_i = 1'b1; m1_sel_i = 4'hF; m1_wdata_i = 32'hDEAD_BEEF;
    got_q.delete();
    log_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      m0_req_i = 1'b1; m1_req_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
        wait_sreq("pair_grant");
        if (s_addr_o == 32'h100) begin
          serve(1, 32'h0);
          m1_req_i = 1'b0;
        end else begin
          serve(1, 32'h13);
          m0_req_i = 1'b0;
        end
      end
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    tick();
    log_en = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_q.push_back(1'(i % 2));
`else
      exp_q.push_back(1'((i + 1) % 2));
`endif
    end
    check("order_len", got_q.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) check($sformatf("order_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end

    // AMO: locked read then write while m0 keeps requesting
    do_reset();
    m1_req_i = 1'b1; m1_lock_i = 1'b1; m1_addr_i = 32'h400; m1_sel_i = 4'h3;
    tick();
    m0_req_i = 1'b1; m0_addr_i = 32'h300;
    serve(1, 32'hCAFE_0001);
    m1_req_i = 1'b0;
    check("lock_hold0", 32'(s_req_o), 32'd0);
    tick();
    check("lock_hold1", 32'(s_req_o), 32'd0);
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_wdata_i = 32'h1234_5678;
    tick();
    check("amo_write_we", 32'(s_we_o), 32'd1);
    check("amo_write_addr", s_addr_o, 32'h400);
    serve(0, 32'h0);
    m1_req_i = 1'b0; m1_lock_i = 1'b0; m1_we_i = 1'b0;
    check("amo_after_write", 32'(s_req_o), 32'd0);
    tick();
    check("amo_unlock_idle", 32'(s_req_o), 32'd0);
    tick();
    check("amo_m0_grant", 32'(s_req_o), 32'd1);
    check("amo_m0_addr", s_addr_o, 32'h300);
    serve(0, 32'h13);
    m0_req_i = 1'b0;
    tick();

    // Timeout: slave never answers
    do_reset();
    m0_req_i = 1'b1; m0_addr_i = 32'h500;
    tick();
    check("tmo_sreq", 32'(s_req_o), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("tmo_err_%0d", k), 32'(m0_err_o), (k == 4) ? 32'd1 : 32'd0);
    end
    check("tmo_no_ack", 32'(m0_ack_o), 32'd0);
    tick();
    m0_req_i = 1'b0;
    check("tmo_release", 32'(s_req_o), 32'd0);
    tick();

    // Ack and timeout in the same cycle: ack wins
    m1_req_i = 1'b1; m1_addr_i = 32'h600;
    tick();
    repeat (4) tick();
    s_ack_i = 1'b1; s_rdata_i = 32'h0000_0AAA;
    #1 check("tie_ack", 32'(m1_ack_o), 32'd1);
    check("tie_err", 32'(m1_err_o), 32'd0);
    tick();
    s_ack_i = 1'b0; s_rdata_i = 32'h0; m1_req_i = 1'b0;
    tick();

    // Reset in GNT1
    m1_req_i = 1'b1; m1_addr_i = 32'h700;
    tick();
    check("rst_gnt1_pre", 32'(s_req_o), 32'd1);
    rst_i = 1'b1; s_ack_i = 1'b1;
    #1 check("rst_gnt1_during", {30'd0, s_req_o, m1_ack_o}, 32'd0);
    tick();
    rst_i = 1'b0; s_ack_i = 1'b0; m1_req_i = 1'b0;
    check("rst_gnt1_after", {30'd0, s_req_o, m1_ack_o}, 32'd0);
    tick();

    // Reset in LOCK, then a normal fetch
    m1_req_i = 1'b1; m1_lock_i = 1'b1; m1_addr_i = 32'h800;
    tick();
    serve(0, 32'h0);
    m1_req_i = 1'b0;
    check("rst_lock_pre", 32'(s_req_o), 32'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m0_req_i = 1'b1; m0_addr_i = 32'h900;
    check("rst_lock_after", {30'd0, s_req_o, m0_ack_o}, 32'd0);
    tick();
    check("rst_lock_m0_grant", 32'(s_req_o), 32'd1);
    check("rst_lock_m0_addr", s_addr_o, 32'h900);
    serve(1, 32'h13);
    m0_req_i = 1'b0; m1_lock_i = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 8'd255, the number of slave wait cycles before the transfer is aborted (range 1..255).
REQ-002 Reset is synchronous and active-high; the reset value follows `RstEnable` from define.v.
REQ-003 The block SHALL have these ports:
- clk_i  in  1  system clock; all state on the rising edge
- rst_i  in  1  synchronous reset, active-high
- m0_req_i  in  1  instruction-fetch request, held until ack or err
- m0_addr_i  in  32  fetch address
- m0_rdata_o  out  32  fetch read data
- m0_ack_o  out  1  fetch transfer complete
- m0_err_o  out  1  fetch timeout
- m1_req_i  in  1  data request, held until ack or err
- m1_we_i  in  1  write enable
- m1_sel_i  in  4  byte lanes
- m1_addr_i  in  32  data address
- m1_wdata_i  in  32  write data
- m1_lock_i  in  1  atomic lock (LR/SC, AMO read-modify-write)
- m1_rdata_o  out  32  data read data
- m1_ack_o  out  1  data transfer complete
- m1_err_o  out  1  data timeout
- s_req_o  out  1  shared-memory request
- s_we_o  out  1  write enable
- s_sel_o  out  4  byte lanes
- s_addr_o  out  32  address
- s_wdata_o  out  32  write data
- s_rdata_i  in  32  slave read data
- s_ack_i  in  1  slave completion, one-cycle pulse

Function
REQ-004 The block SHALL implement an FSM with the states IDLE, GNT0, GNT1 and LOCK.
REQ-005 In IDLE the block SHALL keep s_req_o at 0, select a master from the requests sampled on that edge, and enter GNT0 or GNT1 on the next edge; request-to-s_req_o latency is therefore 1 cycle.
REQ-006 In GNTx the block SHALL drive s_req_o=1, and s_addr_o, s_we_o, s_sel_o and s_wdata_o SHALL be taken from master x.
- For m0: s_we_o=0, s_sel_o=4'hF, s_wdata_o=0.
REQ-007 In GNTx the block SHALL route s_ack_i and s_rdata_i combinationally to mx_ack_o and mx_rdata_o.
- The non-granted master's ack, err and rdata SHALL be 0.
REQ-008 When s_ack_i is sampled in GNT0, the block SHALL go to IDLE; IDLE is a mandatory turnaround cycle.
REQ-009 When s_ack_i is sampled in GNT1 with m1_lock_i=0, the block SHALL go to IDLE.
REQ-010 When s_ack_i is sampled in GNT1 with m1_lock_i=1, the block SHALL go to LOCK.
REQ-011 In LOCK the block SHALL keep s_req_o at 0 and m0 SHALL NOT be granted.
- If m1_req_i=1, go to GNT1 (the lock dominates).
- Else if m1_lock_i=0, go to IDLE.
- Else stay in LOCK.
REQ-012 The 8-bit wait counter SHALL clear on entry to GNTx and increment each GNTx cycle without s_ack_i.
REQ-013 When the wait counter reaches TIMEOUT and s_ack_i=0, the block SHALL pulse mx_err_o for one cycle, with mx_ack_o=0.
- The FSM SHALL then go to IDLE, clearing any lock.
REQ-014 When s_ack_i and the timeout occur in the same cycle, ack SHALL win and err SHALL be 0.
REQ-015 A master dropping its request while granted is illegal; the block SHALL complete the slave transfer and discard the ack.
REQ-016 In IDLE with exactly one request, that master SHALL be granted.
REQ-017 In IDLE with no request, the FSM SHALL stay in IDLE.

Reset
REQ-018 When rst_i is sampled at `RstEnable`, the block SHALL enter IDLE on that edge from any state, including mid-transfer and LOCK.
- The wait counter, the lock and the round-robin pointer SHALL clear to 0.
REQ-019 During reset and on the cycle after it, all outputs SHALL be 0.
- m*_ack_o, m*_err_o and s_req_o SHALL be 0.
- All data, address, sel and we outputs SHALL be 0.

Configuration
REQ-020 With ARB_ROUND_ROBIN_EN defined, the block SHALL break a simultaneous m0/m1 request in IDLE in favour of the master not granted last.
- A 1-bit pointer SHALL be updated on each grant; after reset, m1 is treated as granted last.
REQ-021 With ARB_ROUND_ROBIN_EN undefined, the block SHALL always grant m1 on a simultaneous m0/m1 request (fixed data priority), and no pointer SHALL be implemented.
REQ-022 LOCK behaviour SHALL be identical in both builds.

Verification
REQ-023 A bench SHALL cover these directed scenarios:
- Single fetch: m0_req_i=1, addr=0x00000010; slave acks 2 cycles after s_req_o with rdata=0x00000013 -> s_req_o rises 1 cycle after req; m0_ack_o=1 and m0_rdata_o=0x00000013 in the ack cycle; then IDLE.
- Conflict: m0 and m1 request on the same edge, m1 is a write of 0xDEADBEEF to 0x100 with sel=4'hF -> m1 granted first; m0 granted after 1 IDLE cycle.
- Conflict with the macro defined: 3 back-to-back simultaneous pairs -> grant order m0, m1, m0, m1, m0, m1.
- Conflict without the macro: the same stimulus -> m1, m0 alternation, but m1 always wins each simultaneous IDLE decision.
- AMO: m1 read with m1_lock_i=1, then write, with m0 requesting throughout -> m0 receives no grant until m1_lock_i=0; m0 is then granted within 2 cycles.
- Timeout with TIMEOUT=4, slave never acks -> m0_err_o pulses exactly 4 cycles after s_req_o rises; s_req_o returns to 0.
- rst_i=1 asserted in GNT1 and in LOCK -> on the next cycle s_req_o=0 and all acks are 0; a subsequent m0 request is granted normally.
